ucode_mul_seq: RTL
==================

# ucode_mul_seq

Parametrised microcode sequencer that expands MULI/MULR/MULSI/MULSR into a stream of existing ALU instructions injected through the fetch-side instruction mux. It copies the multiplicand into a scratch register and clears the destination. It then accumulates, using repeated addition or shift-and-add, and negates the result when the multiplier is negative. Output uses a valid/ready handshake so the sequencer holds correctly under pipeline stalls and flushes.

## Interface
Parameters:
- MUL_W, 32, width of the register-form multiplier operand
- IMM_W, 16, width of the immediate-form multiplier (IMM_W ≤ MUL_W)
- ALGO, 0, 0 = repeated add (|m| ADDs); 1 = shift-and-add (scratch doubled per bit)
- SCRATCH_REG, 4'd15, architectural register reserved as scratch

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; accepted only in IDLE
- mul_type  in  2  0 MULI, 1 MULR, 2 MULSI, 3 MULSR
- dest_reg, source_reg  in  4  Rd, Rs
- immediate  in  IMM_W  signed multiplier (I forms)
- reg_operand  in  MUL_W  signed multiplier value (R forms)
- flags_in  in  4  flags at start
- abort  in  1  pipeline flush
- instr_out  out  32  generated instruction; NOP = {5'b11001, 27'b0} when not valid
- instr_valid  out  1  instr_out valid
- instr_ready  in  1  pipeline accepts instr_out
- mux_ctrl  out  1  select sequencer over fetch; equals busy
- busy  out  1  high from the cycle after acceptance through DONE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: illegal register use
- flags_out  out  4  saved flags
- flags_restore  out  1  with done, non-S types only

## Operation
- Opcodes: SUB 0110010, SUBS 0111010, ADD 0110001, ADDS 0111001, SUBI 0010010, NOT 0110110.
- R-format: {op, rd, rs1, rs2, 13'b0}. SUBI: {op, rd, rs1, 1'b0, 16'd1}. NOT: {op, rd, rs1, 17'b0}.
- Accept: latch Rd, Rs, type, flags_in, m = sign-extended immediate (I) or reg_operand (R), neg = m[MUL_W-1], mag = |m| (MUL_W unsigned; 2^(MUL_W-1) is valid).
- Error: Rd==SCRATCH_REG or Rs==SCRATCH_REG → err pulse and no instructions emitted.
- States and their emitted instructions:
  - CLR_T: SUB T,T,T
  - CPY_T: ADD T,T,Rs
  - CLR_D: SUB Rd,Rd,Rd (SUBS for S types)
  - ACC: ADD Rd,Rd,T (ADDS for S types)
  - DBL: ADD T,T,T
  - FIX1: SUBI Rd,Rd,#1
  - FIX2: NOT Rd,Rd
  - DONE: no instruction
- mag==0: CLR_D → DONE directly; the copy is skipped.
- ALGO=0 path: CLR_T → CPY_T → CLR_D → ACC ×mag → (neg ? FIX1 → FIX2) → DONE.
- ALGO=1 path: CLR_T → CPY_T → CLR_D, with r=mag. Each step: if r[0], ACC; then r>>=1; if r≠0, DBL and repeat; else go to fix/DONE.
- Rd==Rs is legal; the copy precedes the clear.
- S types leave the flags produced by the emitted code. Non-S types assert flags_restore with flags_out = saved flags in DONE.

## Timing
- Reset values: state IDLE, instr_out = NOP, and every other output 0. Counters clear.
- Moore outputs: instr_out and instr_valid derive from registered state only.
- Start in cycle N → first instr_valid in N+1. start while busy is ignored. The err pulse is in N+1 with no busy.
- Advancement occurs only on instr_valid && instr_ready. instr_out is held stable while ready is low.
- DONE lasts one cycle: done=1, instr_valid=0. IDLE follows, and a new start is accepted in that IDLE cycle.
- abort beats ready. Any state → IDLE next cycle with no done, no flags_restore, and no further instructions.
- Async reset mid-sequence returns to IDLE immediately.

## Structure
- Shared package ucode_pkg: opcode localparams, NOP word, mul_type encodings, state enum, instruction-format helper functions.
- Sub-module ucode_mag: combinational sign-extend and absolute value (MUL_W), instantiated once at acceptance.

## Test plan
- ALGO=0, MULI Rd=1, Rs=2, imm=3, ready=1 → SUB R15,R15,R15; ADD R15,R15,R2; SUB R1,R1,R1; ADD R1,R1,R15 ×3; then done with flags_restore; 6 instructions.
- ALGO=1, MULSR reg_operand=5 → copy (2), SUBS R1, ADDS R1,R1,R15, DBL, DBL, ADDS R1,R1,R15, done; flags_restore=0.
- MULI imm=16'hFFFD (−3), ALGO=0 → 3 ACCs, then SUBI R1,R1,#1, then NOT R1,R1, then done.
- imm=0 → only SUB Rd,Rd,Rd, then done. Rd=15 → err pulse with no instr_valid.
- ready toggled randomly → identical instruction sequence, with instr_out stable while stalled.
- abort during ACC #2 → IDLE next cycle, no done. A start two cycles later runs a full correct sequence.

Source files
------------

// File: rtl/ucode_pkg.sv
// Shared definitions for the multiply microcode sequencer:
// opcodes, instruction formats, request types and sequencer states.
package ucode_pkg;

   localparam logic [6:0] OP_SUB  = 7'b0110010;
   localparam logic [6:0] OP_SUBS = 7'b0111010;
   localparam logic [6:0] OP_ADD  = 7'b0110001;
   localparam logic [6:0] OP_ADDS = 7'b0111001;
   localparam logic [6:0] OP_SUBI = 7'b0010010;
   localparam logic [6:0] OP_NOT  = 7'b0110110;

   localparam logic [31:0] NOP_W = {5'b11001, 27'b0};

   typedef enum logic [1:0] {
      MT_MULI  = 2'd0,
      MT_MULR  = 2'd1,
      MT_MULSI = 2'd2,
      MT_MULSR = 2'd3
   } mul_type_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CLR_T,
      ST_CPY_T,
      ST_CLR_D,
      ST_ACC,
      ST_DBL,
      ST_FIX1,
      ST_FIX2,
      ST_DONE
   } state_e;

   function automatic logic [31:0] r_fmt(
      input logic [6:0] op,
      input logic [3:0] rd,
      input logic [3:0] rs1,
      input logic [3:0] rs2
   );
      return {op, rd, rs1, rs2, 13'b0};
   endfunction

   function automatic logic [31:0] subi_fmt(
      input logic [3:0] rd,
      input logic [3:0] rs1
   );
      return {OP_SUBI, rd, rs1, 1'b0, 16'd1};
   endfunction

   function automatic logic [31:0] not_fmt(
      input logic [3:0] rd,
      input logic [3:0] rs1
   );
      return {OP_NOT, rd, rs1, 17'b0};
   endfunction

endpackage

// File: rtl/ucode_mag.sv
// Multiplier operand conditioning: sign-extend the immediate form
// and split into sign and unsigned magnitude (2^(MUL_W-1) is representable).
module ucode_mag #(
   parameter int MUL_W = 32,
   parameter int IMM_W = 16
) (
   input  logic             is_imm_i,
   input  logic [IMM_W-1:0] imm_i,
   input  logic [MUL_W-1:0] reg_i,
   output logic             neg_o,
   output logic [MUL_W-1:0] mag_o
);

   logic [MUL_W-1:0] m;

   assign m     = is_imm_i ? MUL_W'(signed'(imm_i)) : reg_i;
   assign neg_o = m[MUL_W-1];
   assign mag_o = neg_o ? (~m + MUL_W'(1)) : m;

endmodule

// File: rtl/ucode_mul_seq.sv
// Expands MUL* requests into ALU instructions injected ahead of fetch,
// multiplying by repeated add (ALGO=0) or shift-and-add (ALGO=1).
module ucode_mul_seq
   import ucode_pkg::*;
#(
   parameter int         MUL_W       = 32,
   parameter int         IMM_W       = 16,
   parameter int         ALGO        = 0,
   parameter logic [3:0] SCRATCH_REG = 4'd15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mul_type,
   input  logic [3:0]       dest_reg,
   input  logic [3:0]       source_reg,
   input  logic [IMM_W-1:0] immediate,
   input  logic [MUL_W-1:0] reg_operand,
   input  logic [3:0]       flags_in,
   input  logic             abort,
   output logic [31:0]      instr_out,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic             mux_ctrl,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [3:0]       flags_out,
   output logic             flags_restore
);

   state_e           state_q;
   logic [3:0]       rd_q;
   logic [3:0]       rs_q;
   logic [3:0]       flags_q;
   logic             s_q;
   logic             neg_q;
   logic             err_q;
   logic [MUL_W-1:0] cnt_q;

   logic             is_imm;
   logic             is_s;
   logic             bad;
   logic             adv;
   logic             m_neg;
   logic [MUL_W-1:0] m_mag;
   logic [MUL_W-1:0] cnt_dn_d;
   logic [MUL_W-1:0] cnt_sh_d;
   state_e           fin_st;

   assign is_imm = (mul_type == MT_MULI) || (mul_type == MT_MULSI);
   assign is_s   = (mul_type == MT_MULSI) || (mul_type == MT_MULSR);
   assign bad    = (dest_reg == SCRATCH_REG) ||
                   (source_reg == SCRATCH_REG);
   assign adv    = instr_valid && instr_ready;

   assign cnt_dn_d = cnt_q - MUL_W'(1);
   assign cnt_sh_d = cnt_q >> 1;
   assign fin_st   = neg_q ? ST_FIX1 : ST_DONE;

   ucode_mag #(
      .MUL_W (MUL_W),
      .IMM_W (IMM_W)
   ) u_mag (
      .is_imm_i (is_imm),
      .imm_i    (immediate),
      .reg_i    (reg_operand),
      .neg_o    (m_neg),
      .mag_o    (m_mag)
   );

   // cnt_q holds the remaining ACC count (ALGO=0) or the unconsumed
   // multiplier bits (ALGO=1); its LSB is the current bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         rd_q    <= '0;
         rs_q    <= '0;
         flags_q <= '0;
         s_q     <= 1'b0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         err_q <= 1'b0;
         if (abort) begin
            state_q <= ST_IDLE;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     rd_q    <= dest_reg;
                     rs_q    <= source_reg;
                     flags_q <= flags_in;
                     s_q     <= is_s;
                     neg_q   <= m_neg;
                     cnt_q   <= m_mag;
                     if (bad)
                        err_q <= 1'b1;
                     else if (m_mag == '0)
                        state_q <= ST_CLR_D;
                     else
                        state_q <= ST_CLR_T;
                  end
               end
               ST_CLR_T: if (adv) state_q <= ST_CPY_T;
               ST_CPY_T: if (adv) state_q <= ST_CLR_D;
               ST_CLR_D: begin
                  if (adv) begin
                     if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                     end else if (ALGO == 0 || cnt_q[0]) begin
                        state_q <= ST_ACC;
                     end else begin
                        cnt_q   <= cnt_sh_d;
                        state_q <= ST_DBL;
                     end
                  end
               end
               ST_ACC: begin
                  if (adv) begin
                     if (ALGO == 0) begin
                        cnt_q <= cnt_dn_d;
                        if (cnt_q == MUL_W'(1))
                           state_q <= fin_st;
                     end else begin
                        cnt_q <= cnt_sh_d;
                        if (cnt_sh_d == '0)
                           state_q <= fin_st;
                        else
                           state_q <= ST_DBL;
                     end
                  end
               end
               ST_DBL: begin
                  if (adv) begin
                     if (cnt_q[0])
                        state_q <= ST_ACC;
                     else
                        cnt_q <= cnt_sh_d;
                  end
               end
               ST_FIX1: if (adv) state_q <= ST_FIX2;
               ST_FIX2: if (adv) state_q <= ST_DONE;
               ST_DONE: state_q <= ST_IDLE;
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      instr_out   = NOP_W;
      instr_valid = 1'b1;
      case (state_q)
         ST_CLR_T: instr_out = r_fmt(OP_SUB, SCRATCH_REG,
                                     SCRATCH_REG, SCRATCH_REG);
         ST_CPY_T: instr_out = r_fmt(OP_ADD, SCRATCH_REG,
                                     SCRATCH_REG, rs_q);
         ST_CLR_D: instr_out = r_fmt(s_q ? OP_SUBS : OP_SUB,
                                     rd_q, rd_q, rd_q);
         ST_ACC:   instr_out = r_fmt(s_q ? OP_ADDS : OP_ADD,
                                     rd_q, rd_q, SCRATCH_REG);
         ST_DBL:   instr_out = r_fmt(OP_ADD, SCRATCH_REG,
                                     SCRATCH_REG, SCRATCH_REG);
         ST_FIX1:  instr_out = subi_fmt(rd_q, rd_q);
         ST_FIX2:  instr_out = not_fmt(rd_q, rd_q);
         default:  instr_valid = 1'b0;
      endcase
   end

   assign busy          = (state_q != ST_IDLE);
   assign mux_ctrl      = busy;
   assign done          = (state_q == ST_DONE);
   assign err           = err_q;
   assign flags_out     = flags_q;
   assign flags_restore = done && !s_q;

endmodule
